// File: rtl/sudoku_wb_pkg.sv
// Shared types and constants for the Wishbone classic single-transfer master.
package sudoku_wb_pkg;

    // Master FSM: wait for a command, run the bus cycle, hold the response.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Default number of unacknowledged BUS cycles before aborting.
    localparam int TIMEOUT_CYCLES_DEF = 255;

    // Width of the BUS-cycle timeout counter.
    localparam int CNT_W = 16;

endpackage

// File: rtl/sudoku_wb_master.sv
// Command/response to Wishbone classic master. One transfer at a time:
// accept a command, drive cyc/stb until ack or timeout, then hold the
// response until it is consumed. Every output is a flop.
module sudoku_wb_master
    import sudoku_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    // command channel
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    // response channel
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    // Wishbone master
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i
);

    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    assign cnt_nxt = cnt + CNT_W'(1);

    // FSM, timeout counter and all registered outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            wb_we_o   <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        wb_adr_o  <= cmd_adr;
                        wb_dat_o  <= cmd_dat;
                        wb_sel_o  <= cmd_sel;
                        wb_we_o   <= cmd_we;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        cnt       <= '0;
                        cmd_ready <= 1'b0;
                        state     <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // ack is checked first so it wins over a same-cycle timeout
                    if (wb_ack_i) begin
                        rsp_dat   <= wb_we_o ? 32'h0 : wb_dat_i;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt == TO_LIMIT) begin
                            rsp_dat   <= 32'h0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            wb_cyc_o  <= 1'b0;
                            wb_stb_o  <= 1'b0;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    wb_cyc_o  <= 1'b0;
                    wb_stb_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sudoku_wb_master.sv
// Bench for sudoku_wb_master with TIMEOUT_CYCLES=4. A negedge slave model
// acks on a chosen BUS cycle; expected responses are queued when the
// command is driven and popped when the DUT presents a response.
module tb_sudoku_wb_master;

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];

    // slave model controls: ack on BUS cycle ack_on (0 = never)
    int          ack_on    = 1;
    logic [31:0] ack_data  = 32'h0;
    logic        ack_force = 1'b0;
    int          bus_cnt   = 0;
    int          last_bus  = 0;

    sudoku_wb_master #(.TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_ack_i (wb_ack_i),
        .wb_dat_i (wb_dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: counts BUS cycles and drives ack/data at the negedge.
    always @(negedge clk) begin
        if (wb_cyc_o && wb_stb_o) begin
            bus_cnt = bus_cnt + 1;
            if (ack_on != 0 && bus_cnt == ack_on) begin
                wb_ack_i = 1'b1;
                wb_dat_i = ack_data;
            end else begin
                wb_ack_i = 1'b0;
                wb_dat_i = $urandom;
            end
        end else begin
            if (bus_cnt != 0) last_bus = bus_cnt;
            bus_cnt  = 0;
            wb_ack_i = ack_force;
            wb_dat_i = $urandom;
        end
    end

    task automatic send_cmd(input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
        @(posedge clk); #1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_we    = $urandom_range(0, 1);
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cmd_sel   = 4'($urandom);
    endtask

    task automatic wait_rsp(output bit got);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL rsp_wait: rsp_valid=0 after 50 cycles, required 1");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctl: got %b, required 100000", {cmd_ready, rsp_valid, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o});
        end
        checks++;
        if ({rsp_dat, wb_adr_o, wb_dat_o, wb_sel_o} !== 100'h0) begin
            failures++;
            $display("FAIL reset_data: rsp_dat=%h adr=%h dat=%h sel=%h, required all 0", rsp_dat, wb_adr_o, wb_dat_o, wb_sel_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_read();
        bit   got;
        exp_t e;
        ack_on   = 3;
        ack_data = 32'h1234_5678;
        exp_q.push_back('{err: 1'b0, dat: 32'h1234_5678});
        send_cmd(1'b0, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o} !== {3'b110, 4'hF, 32'h3000_0004}) begin
            failures++;
            $display("FAIL read_req: cyc=%b stb=%b we=%b sel=%h adr=%h, required 1 1 0 f 30000004", wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL read_busy_ready: cmd_ready=%b, required 0", cmd_ready);
        end
        wait_rsp(got);
        if (got) begin
            e = exp_q.pop_front();
            checks++;
            if ({rsp_err, rsp_dat} !== e) begin
                failures++;
                $display("FAIL read_rsp: err=%b dat=%h, required err=%b dat=%h", rsp_err, rsp_dat, e.err, e.dat);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (last_bus !== 3) begin
            failures++;
            $display("FAIL read_cyc_len: cyc high %0d cycles, required 3", last_bus);
        end
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL read_done: rsp_valid=%b cmd_ready=%b, required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        bit   got;
        exp_t e;
        int   acc_k;
        ack_on   = 1;
        ack_data = 32'hA5A5_0001;
        exp_q.push_back('{err: 1'b0, dat: 32'h0});
        @(posedge clk); #1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h3000_0000;
        cmd_dat   = 32'hCAFE_F00D;
        cmd_sel   = 4'h3;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({wb_cyc_o, wb_we_o, wb_sel_o, wb_dat_o, wb_adr_o} !== {2'b11, 4'h3, 32'hCAFE_F00D, 32'h3000_0000}) begin
            failures++;
            $display("FAIL write_req: cyc=%b we=%b sel=%h dat=%h adr=%h, required 1 1 3 cafef00d 30000000", wb_cyc_o, wb_we_o, wb_sel_o, wb_dat_o, wb_adr_o);
        end
        // second command offered immediately; must not be taken before the 4th cycle
        cmd_we  = 1'b0;
        cmd_adr = 32'h3000_0008;
        exp_q.push_back('{err: 1'b0, dat: 32'hA5A5_0001});
        acc_k = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (rsp_valid && exp_q.size() == 2) begin
                e = exp_q.pop_front();
                checks++;
                if ({rsp_err, rsp_dat} !== e) begin
                    failures++;
                    $display("FAIL write_rsp: err=%b dat=%h, required err=%b dat=%h", rsp_err, rsp_dat, e.err, e.dat);
                end
            end
            if (wb_cyc_o) begin
                acc_k = k;
                break;
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (acc_k !== 3) begin
            failures++;
            $display("FAIL b2b_accept: next accept %0d edges after first, required 3", acc_k);
        end
        checks++;
        if (wb_we_o !== 1'b0 || wb_adr_o !== 32'h3000_0008) begin
            failures++;
            $display("FAIL b2b_req: we=%b adr=%h, required 0 30000008", wb_we_o, wb_adr_o);
        end
        wait_rsp(got);
        if (got) begin
            e = exp_q.pop_front();
            checks++;
            if ({rsp_err, rsp_dat} !== e) begin
                failures++;
                $display("FAIL b2b_rsp: err=%b dat=%h, required err=%b dat=%h", rsp_err, rsp_dat, e.err, e.dat);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        bit   got;
        exp_t e;
        ack_on = 0;
        exp_q.push_back('{err: 1'b1, dat: 32'h0});
        send_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        wait_rsp(got);
        if (got) begin
            e = exp_q.pop_front();
            checks++;
            if ({rsp_err, rsp_dat} !== e) begin
                failures++;
                $display("FAIL timeout_rsp: err=%b dat=%h, required err=%b dat=%h", rsp_err, rsp_dat, e.err, e.dat);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (last_bus !== 4) begin
            failures++;
            $display("FAIL timeout_len: cyc high %0d cycles, required 4", last_bus);
        end
    endtask

    task automatic test_coincide();
        bit   got;
        exp_t e;
        ack_on   = 4;
        ack_data = 32'h0BAD_F00D;
        exp_q.push_back('{err: 1'b0, dat: 32'h0BAD_F00D});
        send_cmd(1'b0, 32'h3000_0014, 32'h0, 4'hF);
        wait_rsp(got);
        if (got) begin
            e = exp_q.pop_front();
            checks++;
            if ({rsp_err, rsp_dat} !== e) begin
                failures++;
                $display("FAIL coincide_rsp: err=%b dat=%h, required err=%b dat=%h", rsp_err, rsp_dat, e.err, e.dat);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (last_bus !== 4) begin
            failures++;
            $display("FAIL coincide_len: cyc high %0d cycles, required 4", last_bus);
        end
    endtask

    task automatic test_backpressure();
        bit          got;
        exp_t        e;
        logic [31:0] held;
        int          bad;
        ack_on    = 2;
        ack_data  = 32'h7777_1111;
        rsp_ready = 1'b0;
        exp_q.push_back('{err: 1'b0, dat: 32'h7777_1111});
        send_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        wait_rsp(got);
        held = rsp_dat;
        if (got) begin
            e = exp_q.pop_front();
            checks++;
            if ({rsp_err, rsp_dat} !== e) begin
                failures++;
                $display("FAIL bp_rsp: err=%b dat=%h, required err=%b dat=%h", rsp_err, rsp_dat, e.err, e.dat);
            end
        end
        // offer a competing command while the response is stalled
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h4000_0000;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_dat !== held || cmd_ready !== 1'b0 || wb_cyc_o !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_stable: %0d of 10 stalled cycles changed state, required 0", bad);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wb_adr_o !== 32'h3000_0020) begin
            failures++;
            $display("FAIL bp_release: rsp_valid=%b cmd_ready=%b adr=%h, required 0 1 30000020", rsp_valid, cmd_ready, wb_adr_o);
        end
    endtask

    task automatic test_reset_mid_bus();
        int bad;
        ack_on = 0;
        send_cmd(1'b1, 32'h3000_0030, 32'h5555_AAAA, 4'hC);
        // now one edge into BUS; reset lands on the 2nd BUS cycle edge
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({wb_cyc_o, wb_stb_o, cmd_ready, rsp_valid, wb_we_o} !== 5'b00100 || wb_adr_o !== 32'h0) begin
            failures++;
            $display("FAIL midbus_reset: cyc=%b stb=%b cmd_ready=%b rsp_valid=%b we=%b adr=%h, required 0 0 1 0 0 0",
                     wb_cyc_o, wb_stb_o, cmd_ready, rsp_valid, wb_we_o, wb_adr_o);
        end
        ack_force = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || wb_cyc_o !== 1'b0 || cmd_ready !== 1'b1) bad++;
        end
        ack_force = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL late_ack: %0d of 5 cycles reacted to stray ack, required 0", bad);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h0;
        cmd_dat   = 32'h0;
        cmd_sel   = 4'h0;
        rsp_ready = 1'b1;
        wb_ack_i  = 1'b0;
        wb_dat_i  = 32'h0;
        test_reset();
        test_read();
        test_back_to_back();
        test_timeout();
        test_coincide();
        test_backpressure();
        test_reset_mid_bus();
        test_read();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
